// File: rtl/lsu_store_align_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_store_align_pkg
//  Brief    : Shared store-size codes, FSM encoding and widths for the store path
//  Revision : 1.0  initial release
// ============================================================================
package lsu_store_align_pkg;

    localparam int ST_DATA_W = 32;
    localparam int ST_STRB_W = ST_DATA_W / 8;

    localparam logic [1:0] ST_SIZE_B = 2'b00;
    localparam logic [1:0] ST_SIZE_H = 2'b01;
    localparam logic [1:0] ST_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } st_state_e;

endpackage : lsu_store_align_pkg
`default_nettype wire

// File: rtl/lsu_store_align_st_lane_gen.sv
`default_nettype none
// ============================================================================
//  Module   : st_lane_gen
//  Brief    : Byte-lane strobes, replicated write data and misalign/illegal flag
//  Revision : 1.0  initial release
// ============================================================================
module st_lane_gen
    import lsu_store_align_pkg::*;
(
    input  logic [1:0]           size,
    input  logic [1:0]           addr_lo,
    input  logic [ST_DATA_W-1:0] data,
    output logic [ST_STRB_W-1:0] strb,
    output logic [ST_DATA_W-1:0] lane_data,
    output logic                 misaligned
);

    always_comb begin
        strb       = '0;
        lane_data  = '0;
        misaligned = 1'b0;
        case (size)
            ST_SIZE_B: begin
                strb      = 4'b0001 << addr_lo;
                lane_data = {4{data[7:0]}};
            end
            ST_SIZE_H: begin
                strb       = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data  = {2{data[15:0]}};
                misaligned = addr_lo[0];
            end
            ST_SIZE_W: begin
                strb       = 4'b1111;
                lane_data  = data;
                misaligned = |addr_lo;
            end
            // size 2'b11 is reported the same way as a misaligned access
            default: misaligned = 1'b1;
        endcase
    end

endmodule : st_lane_gen
`default_nettype wire

// File: rtl/lsu_store_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_store_align
//  Brief    : LSU store path: alignment check, single-outstanding bus write, EXU stall
//  Revision : 1.0  initial release
// ============================================================================
module lsu_store_align
    import lsu_store_align_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [1:0]        st_size,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_done,
    output logic              st_ale,
    output logic              st_bus_err,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [3:0]        wr_strb,
    input  logic              wr_resp_valid,
    input  logic              wr_resp_err,
    output logic              wr_resp_ready
);

    st_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [3:0]        strb_q, strb_d;
    logic              done_q, done_d;
    logic              ale_q, ale_d;
    logic              bus_err_q, bus_err_d;

    logic [3:0]        lane_strb;
    logic [DATA_W-1:0] lane_data;
    logic              lane_misaligned;

    st_lane_gen u_lane_gen (
        .size       (st_size),
        .addr_lo    (st_addr[1:0]),
        .data       (st_data),
        .strb       (lane_strb),
        .lane_data  (lane_data),
        .misaligned (lane_misaligned)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        done_d    = 1'b0;
        ale_d     = 1'b0;
        bus_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (st_valid) begin
                    if (lane_misaligned) begin
                        done_d = 1'b1;
                        ale_d  = 1'b1;
                    end else begin
                        addr_d  = {st_addr[ADDR_W-1:2], 2'b00};
                        data_d  = lane_data;
                        strb_d  = lane_strb;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (wr_ready) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (wr_resp_valid) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    bus_err_d = wr_resp_err;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            done_q    <= 1'b0;
            ale_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            done_q    <= done_d;
            ale_q     <= ale_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Handshake outputs decode straight from state; bus payload comes only from flops
    assign st_ready      = (state_q == ST_IDLE);
    assign wr_valid      = (state_q == ST_REQ);
    assign wr_resp_ready = (state_q == ST_RESP);
    assign wr_addr       = addr_q;
    assign wr_data       = data_q;
    assign wr_strb       = strb_q;
    assign st_done       = done_q;
    assign st_ale        = ale_q;
    assign st_bus_err    = bus_err_q;

endmodule : lsu_store_align
`default_nettype wire

// File: tb/tb_lsu_store_align.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_store_align
//  Brief    : Self-checking bench for lsu_store_align against a behavioural store model
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_store_align;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [1:0]  st_size = 2'b00;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_done, st_ale, st_bus_err;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;
    logic        wr_resp_valid = 1'b0;
    logic        wr_resp_err = 1'b0;
    logic        wr_resp_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_store_align #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .st_size       (st_size),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .st_done       (st_done),
        .st_ale        (st_ale),
        .st_bus_err    (st_bus_err),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_strb       (wr_strb),
        .wr_resp_valid (wr_resp_valid),
        .wr_resp_err   (wr_resp_err),
        .wr_resp_ready (wr_resp_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Store semantics from first principles: access width in bytes, natural alignment,
    // low bytes replicated across every lane, strobe run of 'nbytes' ones at the byte offset.
    function automatic void ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                                      output logic [3:0] es, output logic [31:0] ed, output bit ale);
        int unsigned nbytes, off, run;
        logic [31:0] mask, rep;
        es  = '0;
        ed  = '0;
        ale = 1'b0;
        if (sz == 2'b11) begin
            ale = 1'b1;
            return;
        end
        nbytes = 32'd1 << sz;
        off    = a % 4;
        if ((a % nbytes) != 0) begin
            ale = 1'b1;
            return;
        end
        run  = ((32'd1 << nbytes) - 1) << off;
        es   = run[3:0];
        mask = (nbytes == 4) ? 32'hffff_ffff : ((32'd1 << (8 * nbytes)) - 1);
        rep  = (nbytes == 1) ? 32'h0101_0101 : (nbytes == 2) ? 32'h0001_0001 : 32'h1;
        ed   = (d & mask) * rep;
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge where st_done is visible.
    task automatic run_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                             input int rdly, input int pdly, input logic err);
        logic [3:0]  es;
        logic [31:0] ed;
        bit          ale;
        ref_store(sz, a, d, es, ed, ale);
        check("st_ready_idle", 32'(st_ready), 1);
        st_valid = 1'b1; st_size = sz; st_addr = a; st_data = d;
        @(negedge clk);
        st_valid = 1'b0; st_size = 2'($urandom); st_addr = $urandom; st_data = $urandom;
        if (ale) begin
            check("ale_pulse", {28'd0, st_done, st_ale, st_bus_err, wr_valid}, 32'b1100);
            return;
        end
        check("no_early_done", 32'(st_done), 0);
        for (int i = 0; i <= rdly; i++) begin
            check("req_valid", 32'(wr_valid), 1);
            check("req_addr", wr_addr, {a[31:2], 2'b00});
            check("req_data", wr_data, ed);
            check("req_strb", 32'(wr_strb), 32'(es));
            check("req_stall", {30'd0, st_ready, wr_resp_ready}, 0);
            wr_ready      = (i == rdly);
            wr_resp_valid = 1'($urandom);
            wr_resp_err   = 1'($urandom);
            @(negedge clk);
        end
        wr_ready = 1'b0;
        for (int i = 0; i <= pdly; i++) begin
            check("resp_wait", {29'd0, wr_valid, wr_resp_ready, st_done}, 32'b010);
            wr_resp_valid = (i == pdly);
            wr_resp_err   = (i == pdly) ? err : 1'($urandom);
            @(negedge clk);
        end
        wr_resp_valid = 1'b0;
        wr_resp_err   = 1'b0;
        check("done_pulse", {29'd0, st_done, st_ale, st_bus_err}, {29'd0, 1'b1, 1'b0, err});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_outputs", {26'd0, st_ready, st_done, st_ale, st_bus_err, wr_valid, wr_resp_ready}, 32'b100000);
        check("rst_payload", wr_addr | wr_data | 32'(wr_strb), 0);
        reset = 1'b0;
        @(negedge clk);

        run_store(2'b00, 32'h1c00_0103, 32'h1234_565a, 0, 0, 1'b0);
        run_store(2'b01, 32'h1c00_0102, 32'h0000_abcd, 0, 0, 1'b0);
        run_store(2'b10, 32'h1c00_0104, 32'hdead_beef, 3, 1, 1'b0);
        run_store(2'b01, 32'h1c00_0101, 32'h5555_aaaa, 0, 0, 1'b0);
        run_store(2'b11, 32'h1c00_0100, 32'h0bad_f00d, 0, 0, 1'b0);
        run_store(2'b10, 32'h1c00_0102, 32'h0bad_f00d, 0, 0, 1'b0);
        run_store(2'b00, 32'h8000_0001, 32'h0000_00c3, 1, 2, 1'b1);
        run_store(2'b01, 32'h8000_0000, 32'h7777_1234, 0, 0, 1'b0);

        // Reset while waiting for a response: no done, late response ignored
        st_valid = 1'b1; st_size = 2'b10; st_addr = 32'h0000_0040; st_data = 32'h1111_2222;
        @(negedge clk);
        st_valid = 1'b0; wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        check("rst_in_resp_state", 32'(wr_resp_ready), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_resp_idle", {28'd0, st_ready, wr_valid, wr_resp_ready, st_done}, 32'b1000);
        wr_resp_valid = 1'b1; wr_resp_err = 1'b1;
        @(negedge clk);
        wr_resp_valid = 1'b0; wr_resp_err = 1'b0;
        check("late_resp_ignored", {29'd0, st_ready, st_done, st_bus_err}, 32'b100);

        // Reset while the request is still pending on the bus
        st_valid = 1'b1; st_size = 2'b00; st_addr = 32'h0000_0013; st_data = 32'h0000_0099;
        @(negedge clk);
        st_valid = 1'b0;
        check("rst_in_req_state", 32'(wr_valid), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_req_idle", {29'd0, st_ready, wr_valid, st_done}, 32'b100);

        for (int n = 0; n < 200; n++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0 && sz != 2'b11)
                a = a & ~((32'd1 << sz) - 1);
            run_store(sz, a, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
        end

        @(negedge clk);
        check("done_single_cycle", {29'd0, st_done, st_ale, st_bus_err}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_lsu_store_align
`default_nettype wire
